// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches words over a req/ack memory port and hands them
// to the decoder over valid/ready; redirects squash any fetch already in flight.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc;
    logic        squash;
    logic [31:0] tgt, npc;
    logic        ack, take, hs, new_req;

    assign tgt  = redirect_target & ~32'h3;
    assign npc  = redirect ? tgt : pc;
    assign ack  = state == FETCH && imem_ack;
    // a redirect arriving with the ack kills that data just like a pending squash
    assign take = ack && !squash && !redirect;
    assign hs   = state == HOLD && instr_ready;
    assign new_req = state_nx == FETCH && (state != FETCH || ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = halt ? IDLE : FETCH;
            FETCH:   state_nx = !ack ? FETCH : take ? HOLD : halt ? IDLE : FETCH;
            HOLD:    state_nx = (hs || redirect) ? (halt ? IDLE : FETCH) : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = state == FETCH;
        instr_valid = state == HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            squash    <= 1'b0;
            imem_addr <= RESET_PC;
            instr     <= 32'h0;
            instr_pc  <= RESET_PC;
        end else begin
            pc     <= take ? imem_addr + 32'd4 : npc;
            squash <= state == FETCH && !imem_ack && (squash || redirect);
            if (new_req) imem_addr <= npc;
            if (take) begin
                instr    <= imem_rdata;
                instr_pc <= imem_addr;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios with a behavioural memory; expected deliveries
// are queued by the stimulus and checked by an independent handshake monitor.
module tb_instr_fetch;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        redirect, halt;
    logic [31:0] redirect_target;

    int          total = 0, bad = 0;
    int          lat = 0;
    logic        force_ack = 1'b0;
    logic [31:0] q[$];

    instr_fetch #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_target(redirect_target), .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // memory: acks after lat wait cycles, data = addr ^ K; checks address stability
    initial begin
        int          cnt = 0;
        logic [31:0] held = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            cyc();
            if (force_ack) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (imem_req) begin
                if (cnt == 0) held = imem_addr;
                else chk("addr_stable", imem_addr, held);
                if (cnt >= lat) begin
                    imem_ack = 1'b1;
                    imem_rdata = imem_addr ^ K;
                    cnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_delivery actual_pc=%h required=none", instr_pc);
                end else begin
                    e = q.pop_front();
                    chk("deliv_pc", instr_pc, e);
                    chk("deliv_instr", instr, e ^ K);
                end
            end
        end
    end

    task automatic do_reset(input logic h, input int l);
        rst_n = 1'b0;
        halt = h;
        lat = l;
        instr_ready = 1'b1;
        redirect = 1'b0;
        redirect_target = 32'h0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        halt = 1'b1;
        instr_ready = 1'b1;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!imem_req && !instr_valid) break;
            cyc();
        end
        chk("drain_bound", {31'b0, n < 60}, 32'd1);
        chk("sb_empty", q.size(), 32'd0);
        cyc();
    endtask

    initial begin
        int i;
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        halt = 1'b1;
        instr_ready = 1'b1;
        redirect = 1'b0;
        redirect_target = 32'h0;

        // zero-wait memory, ready high: one instruction every other cycle
        q = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset(1'b0, 0);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) cyc();
            halt = c >= 9;
            @(negedge clk);
            chk($sformatf("s1_valid_c%0d", c), {31'b0, instr_valid}, {31'b0, c == 3 || c == 5 || c == 7 || c == 9});
            chk($sformatf("s1_req_c%0d", c), {31'b0, imem_req}, {31'b0, c == 2 || c == 4 || c == 6 || c == 8});
        end
        drain();

        // slow memory and a stalled decoder
        q = '{32'h0, 32'h4};
        do_reset(1'b0, 3);
        instr_ready = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) cyc();
            instr_ready = c >= 10;
            halt = c >= 11;
            @(negedge clk);
            if (c >= 2 && c <= 5) chk("s2_req_addr", imem_req ? imem_addr : 32'hFFFF_FFFF, 32'h0);
            if (c >= 6 && c <= 10) begin
                chk("s2_hold_valid", {31'b0, instr_valid}, 32'd1);
                chk("s2_hold_pc", instr_pc, 32'h0);
                chk("s2_hold_instr", instr, K);
                chk("s2_no_req", {31'b0, imem_req}, 32'd0);
            end
            if (c == 11) chk("s2_next_addr", imem_req ? imem_addr : 32'hFFFF_FFFF, 32'h4);
        end
        drain();

        // redirect while the fetch of 0x8 is outstanding
        q = '{32'h0, 32'h4, 32'h100};
        do_reset(1'b0, 2);
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) break;
        end
        chk("s3_reach8", {31'b0, i < 40}, 32'd1);
        cyc();
        redirect = 1'b1;
        redirect_target = 32'h100;
        cyc();
        redirect = 1'b0;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_ack) break;
            cyc();
        end
        chk("s3_ack8", {31'b0, i < 10}, 32'd1);
        cyc();
        halt = 1'b1;
        @(negedge clk);
        chk("s3_req_kept", {31'b0, imem_req}, 32'd1);
        chk("s3_new_addr", imem_addr, 32'h100);
        chk("s3_no_valid", {31'b0, instr_valid}, 32'd0);
        drain();

        // IDLE redirect to 0x10, then redirect to 0x203 coincident with its handshake
        do_reset(1'b1, 0);
        instr_ready = 1'b0;
        cyc();
        redirect = 1'b1;
        redirect_target = 32'h10;
        cyc();
        redirect = 1'b0;
        halt = 1'b0;
        cyc();
        @(negedge clk);
        chk("s4_idle_redir", imem_req ? imem_addr : 32'hFFFF_FFFF, 32'h10);
        q = '{32'h10, 32'h200};
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid) break;
        end
        chk("s4_valid10", {31'b0, i < 10}, 32'd1);
        cyc();
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h203;
        cyc();
        redirect = 1'b0;
        halt = 1'b1;
        @(negedge clk);
        chk("s4_req", {31'b0, imem_req}, 32'd1);
        chk("s4_addr", imem_addr, 32'h200);
        chk("s4_valid_drop", {31'b0, instr_valid}, 32'd0);
        drain();

        // halt while holding: no new request until halt drops, then resume at pc+4
        q = '{32'h0, 32'h4};
        do_reset(1'b0, 0);
        instr_ready = 1'b0;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid) break;
        end
        chk("s5_valid", {31'b0, i < 10}, 32'd1);
        cyc();
        halt = 1'b1;
        instr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            instr_ready = 1'b0;
            @(negedge clk);
            chk("s5_halted", {30'b0, imem_req, instr_valid}, 32'd0);
        end
        cyc();
        halt = 1'b0;
        cyc();
        @(negedge clk);
        chk("s5_resume", imem_req ? imem_addr : 32'hFFFF_FFFF, 32'h4);
        drain();

        // wrap past 0xFFFF_FFFC, then reset in the middle of a fetch
        do_reset(1'b1, 3);
        cyc();
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        halt = 1'b0;
        q = '{32'hFFFF_FFFC};
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == 32'hFFFF_FFFC) break;
        end
        chk("s6_valid_top", {31'b0, i < 20}, 32'd1);
        cyc();
        @(negedge clk);
        chk("s6_wrap_req", {31'b0, imem_req}, 32'd1);
        chk("s6_wrap_addr", imem_addr, 32'h0);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("s6_async_req", {31'b0, imem_req}, 32'd0);
        chk("s6_async_addr", imem_addr, 32'h0);
        chk("s6_async_valid", {31'b0, instr_valid}, 32'd0);
        chk("s6_async_instr", instr, 32'h0);
        chk("s6_async_pc", instr_pc, 32'h0);
        halt = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        force_ack = 1'b1;
        cyc();
        @(negedge clk);
        force_ack = 1'b0;
        cyc();
        @(negedge clk);
        chk("s6_stale_valid", {31'b0, instr_valid}, 32'd0);
        chk("s6_stale_instr", instr, 32'h0);
        chk("s6_stale_req", {31'b0, imem_req}, 32'd0);
        chk("s6_sb_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
